// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions used by the gearbox, the block-lock
// state machine and the decoder.
package pcs_pkg;

    localparam int HDR_WIDTH     = 2;
    localparam int PAYLOAD_WIDTH = 64;
    localparam int BLOCK_WIDTH   = HDR_WIDTH + PAYLOAD_WIDTH;

    // Bit-0-first encoding of the 01/10 wire headers
    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b10;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b01;

    typedef struct packed {
        logic [HDR_WIDTH-1:0]     hdr;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } pcs_block_t;

endpackage

// File: rtl/rx_gearbox.sv
// 32-bit to 66-bit RX gearbox with bit-slip block alignment for the
// 10GBASE-R receive path.
module rx_gearbox
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int HDR_WIDTH     = 2,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_data_valid,
    input  logic                     i_slip,
    output logic [HDR_WIDTH-1:0]     o_hdr,
    output logic [PAYLOAD_WIDTH-1:0] o_data,
    output logic                     o_hdr_valid
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("rx_gearbox: only DATA_WIDTH=32 is supported");
    end
    if (HDR_WIDTH + PAYLOAD_WIDTH != BLOCK_WIDTH) begin : g_bad_block_width
        $error("rx_gearbox: HDR_WIDTH+PAYLOAD_WIDTH must equal the PCS block width");
    end

    // Worst case pool is 65 leftover bits plus one full word.
    localparam int BUF_WIDTH = BLOCK_WIDTH - 1 + DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(BUF_WIDTH + 1);

    logic [BUF_WIDTH-1:0] r_buf;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_slip_pend;
    pcs_block_t           r_blk;
    logic                 r_blk_valid;

    logic [BUF_WIDTH-1:0] w_pool;
    logic [CNT_WIDTH-1:0] w_avail;
    logic                 w_slip_pend;
    logic                 w_emit;
    pcs_block_t           w_blk;

    always_comb begin
        w_pool      = r_buf;
        w_avail     = r_cnt;
        w_slip_pend = r_slip_pend;
        w_emit      = 1'b0;
        w_blk       = r_blk;

        if (i_data_valid) begin
            w_pool  = r_buf | ({{(BUF_WIDTH-DATA_WIDTH){1'b0}}, i_data} << r_cnt);
            w_avail = r_cnt + CNT_WIDTH'(DATA_WIDTH);
        end

        // A slip against an empty pool waits for the next cycle with bits.
        if (i_slip || r_slip_pend) begin
            if (w_avail != '0) begin
                w_pool      = w_pool >> 1;
                w_avail     = w_avail - CNT_WIDTH'(1);
                w_slip_pend = 1'b0;
            end else begin
                w_slip_pend = 1'b1;
            end
        end

        if (w_avail >= CNT_WIDTH'(BLOCK_WIDTH)) begin
            w_emit        = 1'b1;
            w_blk.hdr     = w_pool[HDR_WIDTH-1:0];
            w_blk.payload = w_pool[BLOCK_WIDTH-1:HDR_WIDTH];
            w_pool        = w_pool >> BLOCK_WIDTH;
            w_avail       = w_avail - CNT_WIDTH'(BLOCK_WIDTH);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_slip_pend <= 1'b0;
            r_blk       <= '0;
            r_blk_valid <= 1'b0;
        end else begin
            r_buf       <= w_pool;
            r_cnt       <= w_avail;
            r_slip_pend <= w_slip_pend;
            r_blk       <= w_blk;
            r_blk_valid <= w_emit;
        end
    end

    assign o_hdr       = r_blk.hdr;
    assign o_data      = r_blk.payload;
    assign o_hdr_valid = r_blk_valid;

endmodule

// File: tb/tb_rx_gearbox.sv
// Directed self-checking bench for rx_gearbox: aligned stream, offset stream
// with slips and gaps, slip on an empty buffer, and reset mid-block.
module tb_rx_gearbox;
    import pcs_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        i_slip;
    logic [1:0]  o_hdr;
    logic [63:0] o_data;
    logic        o_hdr_valid;

    rx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2), .PAYLOAD_WIDTH(64)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .i_slip      (i_slip),
        .o_hdr       (o_hdr),
        .o_data      (o_data),
        .o_hdr_valid (o_hdr_valid)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pulse_cnt = 0;
    bit          bits_q[$];
    logic [65:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Serialise a block onto the wire bit queue and remember it as expected output.
    task automatic push_block(input logic [1:0] hdr, input logic [63:0] payload);
        for (int i = 0; i < 2; i++) bits_q.push_back(hdr[i]);
        for (int i = 0; i < 64; i++) bits_q.push_back(payload[i]);
        exp_q.push_back({payload, hdr});
    endtask

    task automatic next_word(output logic [31:0] w);
        w = '0;
        for (int i = 0; i < 32; i++) w[i] = (bits_q.size() != 0) ? bits_q.pop_front() : 1'b0;
    endtask

    task automatic cyc(input logic [31:0] d, input logic v, input logic s);
        i_data       = d;
        i_data_valid = v;
        i_slip       = s;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        i_reset_n = 1'b1;
    endtask

    // Every presented block must match the next expected block in order.
    always @(negedge i_clk) begin
        if (o_hdr_valid) begin
            pulse_cnt++;
            chk("blk_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("blk_content", {o_data, o_hdr}, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          b2b;
        int          pulses;
        logic        prev;

        i_reset_n    = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_slip       = 1'b0;
        @(posedge i_clk);
        #1;
        do_reset();
        chk("rst_valid", o_hdr_valid, 0);
        chk("rst_hdr", o_hdr, 0);
        chk("rst_data", o_data, 0);
        chk("rst_cnt", dut.r_cnt, 0);

        // Aligned stream: 16 blocks in 33 words
        for (int k = 0; k < 16; k++) push_block(SYNC_DATA, 64'(k));
        pulses = 0;
        b2b    = 0;
        prev   = 1'b0;
        for (int wi = 0; wi < 33; wi++) begin
            next_word(w);
            cyc(w, 1'b1, 1'b0);
            if (wi == 1) chk("t1_no_early_pulse", o_hdr_valid, 0);
            if (wi == 2) chk("t1_first_pulse", o_hdr_valid, 1);
            if (o_hdr_valid) pulses++;
            if (o_hdr_valid && prev) b2b++;
            prev = o_hdr_valid;
        end
        cyc('0, 1'b0, 1'b0);
        chk("t1_idle_no_pulse", o_hdr_valid, 0);
        chk("t1_pulses_in_33", pulses, 16);
        chk("t1_back_to_back", b2b, 0);
        chk("t1_all_blocks_seen", exp_q.size(), 0);
        chk("t1_cnt_end", dut.r_cnt, 0);

        // Offset stream: 5 junk bits, 5 slips on idle cycles, data gaps
        do_reset();
        bits_q.push_back(1'b1); bits_q.push_back(1'b0); bits_q.push_back(1'b1);
        bits_q.push_back(1'b1); bits_q.push_back(1'b0);
        for (int k = 0; k < 16; k++) push_block(SYNC_DATA, 64'hDEAD_BEEF_0000_0000 | 64'(k));
        pulse_cnt = 0;
        next_word(w);
        cyc(w, 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cyc('0, 1'b0, 1'b1);
            cyc('0, 1'b0, 1'b0);
        end
        chk("t2_cnt_after_slips", dut.r_cnt, 27);
        for (int wi = 1; wi < 34; wi++) begin
            next_word(w);
            cyc(w, 1'b1, 1'b0);
            if (wi % 5 == 0)
                for (int g = 0; g <= wi % 3; g++) cyc('0, 1'b0, 1'b0);
        end
        cyc('0, 1'b0, 1'b0);
        chk("t2_pulse_count", pulse_cnt, 16);
        chk("t2_all_blocks_seen", exp_q.size(), 0);
        chk("t2_cnt_end", dut.r_cnt, 27);

        // Slip on empty buffer; the second request is absorbed
        do_reset();
        bits_q.delete();
        pulse_cnt = 0;
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        chk("t3_cnt_pending", dut.r_cnt, 0);
        cyc(32'hFFFF_FFFE, 1'b1, 1'b0);
        chk("t3_cnt_after_drop", dut.r_cnt, 31);
        exp_q.push_back({64'h0000_0000_1FFF_FFFF, 2'b11});
        cyc('0, 1'b1, 1'b0);
        chk("t3_no_early_pulse", o_hdr_valid, 0);
        cyc('0, 1'b1, 1'b0);
        chk("t3_pulse", o_hdr_valid, 1);
        chk("t3_cnt_after_emit", dut.r_cnt, 29);

        // Build up cnt=40, then reset mid-block
        cyc('0, 1'b1, 1'b0);
        for (int s = 0; s < 21; s++) cyc('0, 1'b0, 1'b1);
        chk("t4_cnt_before_rst", dut.r_cnt, 40);
        chk("t4_data_before_rst", o_data, 64'h0000_0000_1FFF_FFFF);
        i_reset_n = 1'b0;
        cyc(32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("t4_rst_valid", o_hdr_valid, 0);
        chk("t4_rst_hdr", o_hdr, 0);
        chk("t4_rst_data", o_data, 0);
        chk("t4_rst_cnt", dut.r_cnt, 0);
        i_reset_n = 1'b1;
        pulse_cnt = 0;
        push_block(SYNC_CTRL, 64'h0123_4567_89AB_CDEF);
        for (int wi = 0; wi < 3; wi++) begin
            next_word(w);
            cyc(w, 1'b1, 1'b0);
        end
        chk("t4_post_rst_pulse", o_hdr_valid, 1);
        cyc('0, 1'b0, 1'b0);
        chk("t4_pulse_count", pulse_cnt, 1);
        chk("t4_all_blocks_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
